tlatch_bank_ctrl: RTL
=====================

# tlatch_bank_ctrl

Sequencing controller for a WIDTH-bit bank of reversible Fredkin T latches (cells with en, t, q, qb) driven by a shared enable. The latches can only toggle. To write a value, the block converts each command into a toggle mask: target XOR current q. It then fires exactly one single-cycle enable pulse, waits for the cells to settle, and optionally reads back and retries. It sits between the command-issuing logic and the latch bank, and is the only driver of the bank's en and t lines.

## Interface
- WIDTH, 8, bank width in bits (≥ 2)
- SETTLE_CYC, 2, settle cycles after the pulse before readback (≥ 1)
- MAX_RETRY, 3, extra pulse attempts after a readback mismatch (0 = none)

- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 TOGGLE
- cmd_data  in  WIDTH  LOAD value or TOGGLE mask; ignored for INC/DEC
- rsp_valid  out  1  single-cycle completion pulse
- rsp_data  out  WIDTH  bank value at completion
- rsp_err  out  1  readback mismatch after all retries
- lat_t  out  WIDTH  per-cell t lines to the bank
- lat_en  out  1  shared enable to the bank
- lat_q  in  WIDTH  per-cell q readback from the bank

## Operation
- All outputs are registered.
- Reset values: cmd_ready 0 while rst_n is low; rsp_valid 0, rsp_data 0, rsp_err 0, lat_t 0, lat_en 0. State is IDLE.
- States: IDLE, SETUP, PULSE, HOLD, SETTLE, CHECK, DONE.
- IDLE:
  - cmd_ready = 1.
  - A command is accepted when cmd_valid && cmd_ready. Op and data are captured.
  - Next state is SETUP.
- SETUP:
  - Sample lat_q into snap.
  - Compute the target on the first entry only:
    - LOAD: target = cmd_data.
    - INC: target = snap + 1 mod 2^WIDTH (all-ones wraps to 0).
    - DEC: target = snap − 1 mod 2^WIDTH (0 wraps to all-ones).
    - TOGGLE: target = snap ^ cmd_data.
  - mask = target ^ snap.
  - If mask == 0, go to DONE with no pulse. Otherwise drive lat_t = mask and go to PULSE.
- PULSE: lat_en = 1 for exactly one cycle; lat_t held. Next state is HOLD.
- HOLD: lat_en = 0 and lat_t still held, giving one cycle of t hold time. Next state is SETTLE.
- SETTLE: lat_t = 0. Count SETTLE_CYC cycles, then go to CHECK.
- CHECK:
  - If lat_q == target, go to DONE.
  - Else if retry_cnt < MAX_RETRY, increment retry_cnt and go to SETUP. The mask is recomputed from fresh lat_q against the unchanged target.
  - Otherwise go to DONE with the error flag set.
- DONE:
  - rsp_valid = 1 for one cycle, rsp_data = lat_q, rsp_err = error flag.
  - Clear retry_cnt and the error flag. Return to IDLE.
  - There is no response backpressure; the consumer must take rsp_valid when it is asserted.
- Invariants:
  - lat_en is never high on two consecutive cycles.
  - lat_t changes only while lat_en = 0.
- Reset mid-operation: at the next clk edge with rst_n = 0, lat_en and lat_t are forced to 0. The operation is abandoned, no response is issued, and the bank keeps whatever value it holds.

## Timing
- Accept edge is cycle 0.
- Nonzero mask, first-try success: SETUP c1, PULSE c2, HOLD c3, SETTLE c4..c3+SETTLE_CYC, CHECK c4+SETTLE_CYC, DONE c5+SETTLE_CYC.
  - With defaults, rsp_valid is asserted in cycle 7.
- Zero mask: SETUP c1, DONE c2.
- Each retry adds 3 + SETTLE_CYC + 1 cycles (SETUP through CHECK).
- cmd_ready falls the cycle after acceptance and rises the cycle after DONE. Back-to-back commands are therefore spaced by at least one IDLE cycle.

## Configuration
- TLATCH_CTRL_VERIFY_EN defined:
  - CHECK state, retry counter and mismatch detection are compiled in.
  - rsp_data comes from lat_q.
- TLATCH_CTRL_VERIFY_EN undefined:
  - No CHECK state; SETTLE goes directly to DONE.
  - rsp_err is tied to 0 and rsp_data = target.
  - MAX_RETRY is ignored.
  - Latency becomes 4 + SETTLE_CYC cycles for a nonzero mask.

## Test plan
- Reset then LOAD 0xA5 with bank at 0x00:
  - lat_t = 0xA5 during PULSE and HOLD; lat_en high exactly one cycle.
  - rsp_valid at cycle 7 with rsp_data 0xA5, rsp_err 0.
- INC with bank at 0xFF: mask 0xFF, rsp_data 0x00. DEC with bank at 0x00: rsp_data 0xFF.
- LOAD 0x3C with bank already at 0x3C:
  - No lat_en pulse.
  - rsp_valid at cycle 2 with rsp_data 0x3C.
- Bank model with cell 0 stuck (verify enabled):
  - LOAD 0x01 from 0x00 gives 4 pulses total.
  - Then rsp_err 1, rsp_data 0x00.
  - The faulty-cell model is then healed and a LOAD 0x01 is issued; it succeeds with rsp_err 0, showing retry_cnt was cleared.
- rst_n low during HOLD:
  - lat_en and lat_t are 0 at the next edge; no rsp_valid.
  - cmd_ready is 1 on the first cycle after rst_n returns high.
- Random stream of 200 commands with cmd_valid jitter:
  - lat_en never high for 2 consecutive cycles.
  - Every accepted command yields exactly one rsp_valid.
  - rsp_data matches the reference-model target.

Source files
------------

// File: rtl/tlatch_bank_ctrl.sv
// tlatch_bank_ctrl: sequencing controller for a bank of toggle-only T latches.
// A command becomes a toggle mask (target ^ q). The controller fires one
// single-cycle shared enable pulse, holds t for one cycle and then waits for
// the cells to settle.
// Build option TLATCH_CTRL_VERIFY_EN compiles in the readback check and the
// retry loop. Without it, SETTLE goes straight to DONE and rsp_data reports
// the target.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a command
// SETUP  | sample lat_q, fix the target on first entry, compute the mask
// PULSE  | lat_en high for one cycle, lat_t = mask
// HOLD   | lat_en low, lat_t still held (t hold time)
// SETTLE | lat_t cleared, count SETTLE_CYC cycles
// CHECK  | compare readback to the target, then retry or flag an error
// DONE   | one-cycle response
module tlatch_bank_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    output logic             rsp_valid_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] lat_t_o,
    output logic             lat_en_o,
    input  logic [WIDTH-1:0] lat_q_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_PULSE  = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    localparam int CW = $clog2(SETTLE_CYC + 1);

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             first_q, first_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cmd_ready_q, rsp_valid_q, lat_en_q;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0] lat_t_q, lat_t_d;
    logic [WIDTH-1:0] calc, tgt_now, mask;

`ifdef TLATCH_CTRL_VERIFY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
    logic          err_q, err_d;
    logic          rsp_err_q;
`else
    logic unused_max_retry;
    assign unused_max_retry = (MAX_RETRY == 0);
`endif

    // Next-state and datapath decisions; outputs are registered from state_d.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        target_d   = target_q;
        first_d    = first_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        lat_t_d    = lat_t_q;
`ifdef TLATCH_CTRL_VERIFY_EN
        retry_d    = retry_q;
        err_d      = err_q;
`endif
        calc = data_q;
        case (op_q)
            OP_LOAD: calc = data_q;
            OP_INC:  calc = lat_q_i + 1'b1;
            OP_DEC:  calc = lat_q_i - 1'b1;
            OP_TGL:  calc = lat_q_i ^ data_q;
        endcase
        // On a retry the target stays fixed; only the mask is recomputed.
        tgt_now = first_q ? calc : target_q;
        mask    = tgt_now ^ lat_q_i;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    op_d    = cmd_op_i;
                    data_d  = cmd_data_i;
                    first_d = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                target_d = tgt_now;
                first_d  = 1'b0;
                if (mask == '0) begin
`ifdef TLATCH_CTRL_VERIFY_EN
                    rsp_data_d = lat_q_i;
`else
                    rsp_data_d = tgt_now;
`endif
                    state_d = S_DONE;
                end else begin
                    lat_t_d = mask;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: state_d = S_HOLD;
            S_HOLD: begin
                lat_t_d = '0;
                cnt_d   = CW'(SETTLE_CYC - 1);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
`ifdef TLATCH_CTRL_VERIFY_EN
                    state_d = S_CHECK;
`else
                    rsp_data_d = target_q;
                    state_d    = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef TLATCH_CTRL_VERIFY_EN
            S_CHECK: begin
                if (lat_q_i == target_q) begin
                    rsp_data_d = lat_q_i;
                    state_d    = S_DONE;
                end else if (32'(retry_q) < MAX_RETRY) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_SETUP;
                end else begin
                    err_d      = 1'b1;
                    rsp_data_d = lat_q_i;
                    state_d    = S_DONE;
                end
            end
`endif
            S_DONE: begin
`ifdef TLATCH_CTRL_VERIFY_EN
                retry_d = '0;
                err_d   = 1'b0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LOAD;
            data_q      <= '0;
            target_q    <= '0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            lat_t_q     <= '0;
            lat_en_q    <= 1'b0;
`ifdef TLATCH_CTRL_VERIFY_EN
            retry_q     <= '0;
            err_q       <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            target_q    <= target_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_DONE);
            rsp_data_q  <= rsp_data_d;
            lat_t_q     <= lat_t_d;
            lat_en_q    <= (state_d == S_PULSE);
`ifdef TLATCH_CTRL_VERIFY_EN
            retry_q     <= retry_d;
            err_q       <= err_d;
            rsp_err_q   <= (state_d == S_DONE) && err_d;
`endif
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign lat_t_o     = lat_t_q;
    assign lat_en_o    = lat_en_q;
`ifdef TLATCH_CTRL_VERIFY_EN
    assign rsp_err_o   = rsp_err_q;
`else
    assign rsp_err_o   = 1'b0;
`endif

endmodule
